// File: rtl/otter_cu_pkg.sv
// Shared types for the OTTER multicycle control unit: opcodes, SYSTEM func3 codes,
// FSM states and the cause-index width helper.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_INTER,
    ST_TRAP
  } state_t;

  localparam logic [11:0] MRET_FUNC12 = 12'h302;

  // A single source still needs a one-bit cause field.
  function automatic int causeW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otter_cu_hs_fsm_irq_arb.sv
// Interrupt arbiter: latches masked requests, picks the lowest pending index
// and produces the one-hot acknowledge for the source being serviced.
module otter_irq_arb
  import otter_cu_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_IRQ-1:0]           i_irq,
  input  logic [NUM_IRQ-1:0]           i_mask,
  input  logic                         i_capture,
  input  logic                         i_clear,
  output logic                         o_any,
  output logic [causeW(NUM_IRQ)-1:0]   o_cause,
  output logic [NUM_IRQ-1:0]           o_clrOneHot
);

  localparam int CW = causeW(NUM_IRQ);

  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_eff;
  logic [CW-1:0]      r_cause;
  logic [CW-1:0]      w_cause;

  // Requests raised this very cycle count, so an IRQ arriving at a boundary is taken there.
  assign w_set = i_irq & i_mask;
  assign w_eff = r_pend | w_set;
  assign o_any = |w_eff;

  always_comb begin
    w_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eff[i]) w_cause = CW'(i);
    end
  end

  assign o_clrOneHot = i_clear ? (NUM_IRQ'(1) << r_cause) : '0;
  assign o_cause     = r_cause;

  // The acknowledge beats a same-cycle re-request on the serviced bit only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend  <= '0;
      r_cause <= '0;
    end else begin
      r_pend <= w_eff & ~o_clrOneHot;
      if (i_capture) r_cause <= w_cause;
    end
  end

endmodule

// File: rtl/otter_cu_hs_fsm.sv
// Multicycle OTTER control FSM with memory-ready handshake and interrupt entry.
// Define CU_TIMEOUT_EN to enable the memory-wait watchdog that traps to TRAP.
module otter_cu_hs_fsm
  import otter_cu_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                        CU_CLK,
  input  logic                        CU_RESET,
  input  logic [6:0]                  CU_OPCODE,
  input  logic [2:0]                  CU_FUNC3,
  input  logic [11:0]                 CU_FUNC12,
  input  logic [NUM_IRQ-1:0]          CU_IRQ,
  input  logic [NUM_IRQ-1:0]          CU_IRQ_MASK,
  input  logic                        CU_MIE,
  input  logic                        CU_MEM_READY,
  output logic                        CU_PCWRITE,
  output logic                        CU_REGWRITE,
  output logic                        CU_MEMWRITE,
  output logic                        CU_MEMREAD1,
  output logic                        CU_MEMREAD2,
  output logic                        CU_csrWrite,
  output logic                        CU_mret,
  output logic                        CU_intTaken,
  output logic [causeW(NUM_IRQ)-1:0]  CU_intCAUSE,
  output logic [NUM_IRQ-1:0]          CU_intCLR,
  output logic                        CU_busErr
);

  localparam int CW = causeW(NUM_IRQ);

  state_t             r_state;
  state_t             w_next;
  logic               w_isLoad;
  logic               w_isStore;
  logic               w_isBranch;
  logic               w_isSystem;
  logic               w_isMret;
  logic               w_isCsr;
  logic               w_isKnown;
  logic               w_anyPend;
  logic               w_take;
  logic               w_timeout;
  logic [CW-1:0]      w_causeReg;
  logic [NUM_IRQ-1:0] w_clr;

  assign w_isLoad   = (CU_OPCODE == OP_LOAD);
  assign w_isStore  = (CU_OPCODE == OP_STORE);
  assign w_isBranch = (CU_OPCODE == OP_BRANCH);
  assign w_isSystem = (CU_OPCODE == OP_SYSTEM);
  assign w_isCsr    = (CU_FUNC3 == F3_CSRRW)  || (CU_FUNC3 == F3_CSRRS)  || (CU_FUNC3 == F3_CSRRC) ||
                      (CU_FUNC3 == F3_CSRRWI) || (CU_FUNC3 == F3_CSRRSI) || (CU_FUNC3 == F3_CSRRCI);
  assign w_isMret   = w_isSystem && (CU_FUNC3 == F3_PRIV) && (CU_FUNC12 == MRET_FUNC12);
  assign w_isKnown  = (CU_OPCODE == OP_LUI) || (CU_OPCODE == OP_AUIPC) || (CU_OPCODE == OP_JAL) ||
                      (CU_OPCODE == OP_JALR) || w_isBranch || (CU_OPCODE == OP_IMM) ||
                      (CU_OPCODE == OP_REG) || w_isSystem;
  assign w_take     = CU_MIE && w_anyPend;

  otter_irq_arb #(
    .NUM_IRQ (NUM_IRQ)
  ) u_arb (
    .i_clk       (CU_CLK),
    .i_reset     (CU_RESET),
    .i_irq       (CU_IRQ),
    .i_mask      (CU_IRQ_MASK),
    .i_capture   (!CU_RESET && (w_next == ST_INTER)),
    .i_clear     (!CU_RESET && (r_state == ST_INTER)),
    .o_any       (w_anyPend),
    .o_cause     (w_causeReg),
    .o_clrOneHot (w_clr)
  );

`ifdef CU_TIMEOUT_EN
  localparam int              TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(MEM_TIMEOUT);

  logic [TW-1:0] r_waitCnt;

  assign w_timeout = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !CU_MEM_READY &&
                     (r_waitCnt == TO_LIMIT);

  // Counts consecutive not-ready cycles spent in one FETCH or MEM visit.
  always_ff @(posedge CU_CLK) begin
    if (CU_RESET) begin
      r_waitCnt <= '0;
    end else if ((w_next != r_state) || CU_MEM_READY) begin
      r_waitCnt <= '0;
    end else if ((r_state == ST_FETCH) || (r_state == ST_MEM)) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (MEM_TIMEOUT != 0);
  assign w_timeout       = 1'b0;
`endif

  always_ff @(posedge CU_CLK) begin
    if (CU_RESET) r_state <= ST_FETCH;
    else          r_state <= w_next;
  end

  // Reset masks every enable so an abandoned access never completes.
  always_comb begin
    w_next      = r_state;
    CU_PCWRITE  = 1'b0;
    CU_REGWRITE = 1'b0;
    CU_MEMWRITE = 1'b0;
    CU_MEMREAD1 = 1'b0;
    CU_MEMREAD2 = 1'b0;
    CU_csrWrite = 1'b0;
    CU_mret     = 1'b0;
    CU_intTaken = 1'b0;
    CU_intCAUSE = '0;
    CU_intCLR   = '0;
    CU_busErr   = 1'b0;
    if (!CU_RESET) begin
      unique case (r_state)
        ST_FETCH: begin
          CU_MEMREAD1 = 1'b1;
          if (CU_MEM_READY)   w_next = ST_EXECUTE;
          else if (w_timeout) w_next = ST_TRAP;
        end
        ST_EXECUTE: begin
          if (w_isLoad || w_isStore) begin
            w_next = ST_MEM;
          end else begin
            CU_PCWRITE  = 1'b1;
            CU_REGWRITE = w_isKnown && !w_isBranch && !w_isMret;
            CU_csrWrite = w_isSystem && w_isCsr;
            CU_mret     = w_isMret;
            w_next      = w_take ? ST_INTER : ST_FETCH;
          end
        end
        ST_MEM: begin
          CU_MEMREAD2 = w_isLoad;
          CU_MEMWRITE = w_isStore;
          if (CU_MEM_READY) begin
            if (w_isLoad) begin
              w_next = ST_WB;
            end else begin
              CU_PCWRITE = 1'b1;
              w_next     = w_take ? ST_INTER : ST_FETCH;
            end
          end else if (w_timeout) begin
            w_next = ST_TRAP;
          end
        end
        ST_WB: begin
          CU_REGWRITE = 1'b1;
          CU_PCWRITE  = 1'b1;
          w_next      = w_take ? ST_INTER : ST_FETCH;
        end
        ST_INTER: begin
          CU_intTaken = 1'b1;
          CU_PCWRITE  = 1'b1;
          CU_intCAUSE = w_causeReg;
          CU_intCLR   = w_clr;
          w_next      = ST_FETCH;
        end
        ST_TRAP: begin
          CU_PCWRITE = 1'b1;
`ifdef CU_TIMEOUT_EN
          CU_busErr  = 1'b1;
`endif
          w_next     = ST_FETCH;
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

endmodule
